// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - instruction decode stage with RAW scoreboard interlock (optional macro: DECODE_ILLEGAL_EN)
module decode_stage #(
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic [4:0]  rf_rr1,
  output logic [4:0]  rf_rr2,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [6:0]  out_opcode,
  output logic [2:0]  out_funct3,
  output logic        out_funct7b5,
  output logic [4:0]  out_rd,
  output logic        out_rd_we,
`ifdef DECODE_ILLEGAL_EN
  output logic        out_illegal,
`endif
  output logic [31:0] out_imm
);

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_MISC   = 7'h0F;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  // Last value of the wb-free cycle counter before read data is trusted
  localparam logic [1:0] LAST_CNT = 2'(READ_LAT - 1);

  typedef enum logic [1:0] {S_EMPTY, S_CHECK, S_READ, S_VALID} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] busy_q, busy_d;

  logic [6:0]  opcode_w;
  logic [4:0]  rd_w, rs1_w, rs2_w;
  logic [31:0] imm_w;
  logic        rd_we_w, uses_rs1_w, uses_rs2_w, illegal_w;
  logic        hazard_w, accept_w, handoff_w;

  assign opcode_w = instr_q[6:0];
  assign rd_w     = instr_q[11:7];
  assign rs1_w    = instr_q[19:15];
  assign rs2_w    = instr_q[24:20];

  // Field decode of the held instruction: immediate format, rd write, source usage
  always_comb begin
    illegal_w = 1'b0;
`ifdef DECODE_ILLEGAL_EN
    case (opcode_w)
      OPC_LOAD, OPC_MISC, OPC_OPIMM, OPC_AUIPC, OPC_STORE, OPC_OP,
      OPC_LUI, OPC_BRANCH, OPC_JALR, OPC_JAL, OPC_SYSTEM: illegal_w = 1'b0;
      default: illegal_w = 1'b1;
    endcase
`endif
    imm_w      = '0;
    rd_we_w    = 1'b0;
    uses_rs1_w = 1'b1;
    uses_rs2_w = 1'b0;
    case (opcode_w)
      OPC_OPIMM, OPC_LOAD, OPC_JALR: begin
        imm_w   = {{20{instr_q[31]}}, instr_q[31:20]};
        rd_we_w = 1'b1;
      end
      OPC_STORE: begin
        imm_w      = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
        uses_rs2_w = 1'b1;
      end
      OPC_BRANCH: begin
        imm_w      = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
        uses_rs2_w = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm_w      = {instr_q[31:12], 12'b0};
        rd_we_w    = 1'b1;
        uses_rs1_w = 1'b0;
      end
      OPC_JAL: begin
        imm_w      = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};
        rd_we_w    = 1'b1;
        uses_rs1_w = 1'b0;
      end
      OPC_OP: begin
        rd_we_w    = 1'b1;
        uses_rs2_w = 1'b1;
      end
      default: ;
    endcase
    if (rd_w == 5'd0) rd_we_w = 1'b0;
    // Illegal bundles pass straight through: no result, no interlock
    if (illegal_w) begin
      imm_w      = '0;
      rd_we_w    = 1'b0;
      uses_rs1_w = 1'b0;
      uses_rs2_w = 1'b0;
    end
  end

  // Hazard looks only at the registered scoreboard, so a release lands one cycle after wb_en
  assign hazard_w  = (uses_rs1_w && busy_q[rs1_w]) || (uses_rs2_w && busy_q[rs2_w]);
  assign in_ready  = !flush && ((state_q == S_EMPTY) || ((state_q == S_VALID) && out_ready));
  assign accept_w  = in_valid && in_ready;
  assign handoff_w = (state_q == S_VALID) && out_ready && !flush;

  // Next-state: capture, hazard wait, read-latency count, handoff; flush overrides
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (accept_w) begin
      instr_d = in_instr;
      pc_d    = in_pc;
    end
    case (state_q)
      S_EMPTY: if (accept_w) state_d = S_CHECK;
      S_CHECK: begin
        if (!hazard_w) begin
          state_d = S_READ;
          cnt_d   = '0;
        end
      end
      S_READ: begin
        // A write cycle leaves stale read data, so the wait starts over
        if (wb_en) begin
          cnt_d = '0;
        end else if (cnt_q == LAST_CNT) begin
          state_d = S_VALID;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_VALID: begin
        if (handoff_w) state_d = accept_w ? S_CHECK : S_EMPTY;
      end
      default: state_d = S_EMPTY;
    endcase
    if (flush) state_d = S_EMPTY;
  end

  // Scoreboard update: clear on writeback, then set on handoff so set wins
  always_comb begin
    busy_d = busy_q;
    if (wb_en) busy_d[wb_rd] = 1'b0;
    if (handoff_w && rd_we_w) busy_d[rd_w] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // State, held instruction and scoreboard registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      cnt_q   <= '0;
      instr_q <= '0;
      pc_q    <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      busy_q  <= busy_d;
    end
  end

  // Output gating: bundle only in VALID, read addresses whenever an instruction is held
  always_comb begin
    out_valid    = (state_q == S_VALID);
    out_pc       = '0;
    out_opcode   = '0;
    out_funct3   = '0;
    out_funct7b5 = 1'b0;
    out_rd       = '0;
    out_rd_we    = 1'b0;
    out_imm      = '0;
`ifdef DECODE_ILLEGAL_EN
    out_illegal  = 1'b0;
`endif
    if (state_q == S_VALID) begin
      out_pc       = pc_q;
      out_opcode   = opcode_w;
      out_funct3   = instr_q[14:12];
      out_funct7b5 = instr_q[30];
      out_rd       = rd_w;
      out_rd_we    = rd_we_w;
      out_imm      = imm_w;
`ifdef DECODE_ILLEGAL_EN
      out_illegal  = illegal_w;
`endif
    end
    rf_rr1 = (state_q == S_EMPTY) ? 5'd0 : rs1_w;
    rf_rr2 = (state_q == S_EMPTY) ? 5'd0 : rs2_w;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction decode stage sitting directly upstream of the register file.
- Accepts fetched instructions over a valid/ready handshake and extracts fields and immediates.
- Drives the register file read addresses and waits out its one-cycle registered read latency.
- Interlocks on read-after-write hazards with a 32-entry scoreboard, then presents a decoded bundle to execute over a second valid/ready handshake.

Parameters:
READ_LAT, 1, cycles spent in READ before the register file read data counts as valid (range 1-3).

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  fetch offers instruction
in_ready  out  1  stage can accept
in_instr  in  32  instruction word
in_pc  in  32  instruction address
flush  in  1  synchronous kill of the held instruction
rf_rr1  out  5  register file read address 1 (rs1 field of held instruction)
rf_rr2  out  5  register file read address 2 (rs2 field)
wb_en  in  1  writeback retiring a result this cycle (same signal as register file write enable)
wb_rd  in  5  register being written back
out_valid  out  1  decoded bundle valid
out_ready  in  1  execute accepts bundle
out_pc  out  32  pc of bundle
out_opcode  out  7  instr[6:0]
out_funct3  out  3  instr[14:12]
out_funct7b5  out  1  instr[30]
out_rd  out  5  destination register
out_rd_we  out  1  bundle writes rd (rd!=0 and opcode in OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR)
out_imm  out  32  sign-extended immediate

Behaviour:
- Reset: state=EMPTY, scoreboard all 0, held instruction 0 (0x00000000). All out_* outputs are 0 and rf_rr1/rf_rr2 are 0; in_ready is combinational: 1 in EMPTY.
- FSM states:
  - EMPTY -> CHECK on in_valid&&in_ready.
  - CHECK -> READ when no hazard; stays in CHECK otherwise.
  - READ -> VALID after READ_LAT consecutive cycles with wb_en=0. Any cycle with wb_en=1 restarts the count, because the register file does not refresh read data on write cycles.
  - VALID -> EMPTY on out_valid&&out_ready with in_valid=0.
  - VALID -> CHECK on handoff with a simultaneous accept.
- in_ready = (state==EMPTY) || (state==VALID && out_ready). out_valid = (state==VALID).
- Hazard: busy[rs1] where rs1 is used (all opcodes except LUI, AUIPC, JAL); busy[rs2] where rs2 is used (OP, STORE, BRANCH). Checked against the registered scoreboard only, so a release becomes visible the cycle after wb_en.
- Scoreboard:
  - Set: busy[out_rd] on handoff when out_rd_we.
  - Clear: busy[wb_rd] when wb_en.
  - Set and clear of the same register in the same cycle: set wins.
  - busy[0] is constant 0.
- Immediates:
  - I (OP-IMM, LOAD, JALR): {20{i[31]}, i[31:20]}.
  - S: {20{i[31]}, i[31:25], i[11:7]}.
  - B: {19{i[31]}, i[31], i[7], i[30:25], i[11:8], 0}.
  - U: {i[31:12], 12'b0}.
  - J: {11{i[31]}, i[31], i[19:12], i[20], i[30:21], 0}.
  - OP: 0.
- Decoded outputs are combinational from the held instruction but forced to 0 unless state==VALID. rf_rr1/rf_rr2 track the held instruction in CHECK, READ and VALID.
- Bundle outputs are stable while out_valid && !out_ready.
- flush: synchronous, overrides all else; next state EMPTY. in_ready=0 during a flush cycle. Scoreboard unchanged, except that a wb_en clear in the same cycle still applies.
- Reset mid-operation: state returns to EMPTY and the scoreboard clears immediately; any in-flight handshake is dropped.

Optional Feature:
DECODE_ILLEGAL_EN
- Defined:
  - Adds output out_illegal (1 bit), asserted in VALID when the opcode is outside the RV32I base set or instr[1:0]!=2'b11.
  - Illegal bundles have out_rd_we=0, imm=0, skip the hazard check and never set the scoreboard.
- Undefined:
  - The port is absent.
  - Unknown opcodes decode with out_rd_we=0 and imm=0 but are still hazard-checked on rs1.

Test Plan:
- Reset release, in_valid=0 -> in_ready=1, out_valid=0, rf_rr1=rf_rr2=0, all outputs 0.
- 0x00500093 (addi x1,x0,5), out_ready=1, no wb -> out_valid 2 cycles after acceptance with out_rd=1, out_rd_we=1, out_imm=5, out_opcode=0x13; busy[1]=1 after handoff.
- Then 0x002081B3 (add x3,x1,x2) -> holds in CHECK with rf_rr1=1, rf_rr2=2. Pulse wb_en, wb_rd=1 -> READ next cycle, VALID after one wb-free cycle, out_imm=0.
- 0x0020A423 (sw x2,8(x1)) with wb_en=1 held 3 cycles during READ -> out_valid is delayed 3 cycles; out_imm=8, out_rd_we=0.
- 0x123452B7 (lui x5) with out_ready=0 for 4 cycles -> out_imm=0x12345000 stable, in_ready=0; flush in cycle 2 -> EMPTY, out_valid=0, busy[5]=0.
- With DECODE_ILLEGAL_EN: 0xFFFFFFFF -> out_illegal=1, out_rd_we=0, no scoreboard bit set, and no stall even when busy[31]=1.
